// File: rtl/nfc_physical_output_gen2_pkg.sv
// Shared definitions for the NFC physical output stage: tristate FSM
// encoding, bus idle levels and legal parameter ranges.
package NFC_PHY_pkg;

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } tristateState_t;

    // Idle (released) levels of the NAND control and strobe lines
    localparam logic       CEIdle  = 1'b1;
    localparam logic [1:0] WEIdle  = 2'b11;
    localparam logic [1:0] REIdle  = 2'b11;
    localparam logic [1:0] ALEIdle = 2'b00;
    localparam logic [1:0] CLEIdle = 2'b00;
    localparam logic [1:0] DQSIdle = 2'b00;

    // Legal parameter ranges
    localparam int unsigned MinNumberOfWays     = 1;
    localparam int unsigned MaxNumberOfWays     = 8;
    localparam int unsigned MinPipelineDepth    = 1;
    localparam int unsigned MaxPipelineDepth    = 4;
    localparam int unsigned MaxTurnaroundCycles = 7;

endpackage

// File: rtl/nfc_physical_output_gen2_sequencer.sv
// Tristate sequencer for one pin group: delays the drive request so the
// T register lines up with the data pipeline, then walks HIZ/DRIVE/TURN
// with a forced Hi-Z guard after each release.
module NFC_Tristate_Sequencer
    import NFC_PHY_pkg::*;
#(
    parameter int unsigned PipelineDepth    = 2,
    parameter int unsigned TurnaroundCycles = 2
) (
    input  logic iSystemClock,
    input  logic iModuleReset,
    input  logic iForceIdle,
    input  logic iEnable,
    output logic oTristate,
    output logic oConflict,
    output logic oHiZ
);

    localparam int unsigned DelayStages = PipelineDepth - 1;
    localparam logic [2:0]  TurnLoad    = (TurnaroundCycles == 0) ? 3'd0 : 3'(TurnaroundCycles - 1);

    tristateState_t rState;
    logic [2:0]     rCount;
    logic           wDelayedEnable;

    generate
        if (DelayStages == 0) begin : gNoDelay
            assign wDelayedEnable = iEnable;
        end else begin : gDelay
            logic rDelay [DelayStages];

            // Enable delay line, flushed together with the data pipeline
            always_ff @(posedge iSystemClock) begin
                if (iModuleReset || iForceIdle) begin
                    for (int unsigned i = 0; i < DelayStages; i++) rDelay[i] <= 1'b0;
                end else begin
                    for (int unsigned i = DelayStages - 1; i > 0; i--) rDelay[i] <= rDelay[i-1];
                    rDelay[0] <= iEnable;
                end
            end

            assign wDelayedEnable = rDelay[DelayStages-1];
        end
    endgenerate

    // HIZ/DRIVE/TURN state machine with registered T and conflict pulse
    always_ff @(posedge iSystemClock) begin
        if (iModuleReset || iForceIdle) begin
            rState    <= HIZ;
            rCount    <= '0;
            oTristate <= 1'b1;
            oConflict <= 1'b0;
        end else begin
            oConflict <= 1'b0;
            unique case (rState)
                HIZ: begin
                    if (wDelayedEnable) begin
                        rState    <= DRIVE;
                        oTristate <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (!wDelayedEnable) begin
                        oTristate <= 1'b1;
                        if (TurnaroundCycles == 0) begin
                            rState <= HIZ;
                        end else begin
                            rState <= TURN;
                            rCount <= TurnLoad;
                        end
                    end
                end
                TURN: begin
                    // A request during the guard is refused; the countdown continues
                    oConflict <= wDelayedEnable;
                    if (rCount == '0) rState <= HIZ;
                    else              rCount <= rCount - 3'd1;
                end
                default: begin
                    rState    <= HIZ;
                    oTristate <= 1'b1;
                end
            endcase
        end
    end

    assign oHiZ = (rState == HIZ);

endmodule

// File: rtl/nfc_physical_output_gen2.sv
// NAND physical output stage: fixed-latency pipeline for DQ/DQS and control
// phase pairs, plus tristate sequencing for the DQS and DQ pin groups.
module nfc_physical_output_gen2
    import NFC_PHY_pkg::*;
#(
    parameter int unsigned NumberOfWays     = 4,
    parameter int unsigned DQWidth          = 8,
    parameter int unsigned PipelineDepth    = 2,
    parameter int unsigned TurnaroundCycles = 2
) (
    input  logic                      iSystemClock,
    input  logic                      iModuleReset,
    input  logic                      iDQSOutEnable,
    input  logic                      iDQOutEnable,
    input  logic                      iForceIdle,
    input  logic [1:0]                iPO_DQStrobe,
    input  logic [2*DQWidth-1:0]      iPO_DQ,
    input  logic [NumberOfWays-1:0]   iPO_ChipEnable,
    input  logic [1:0]                iPO_ReadEnable,
    input  logic [1:0]                iPO_WriteEnable,
    input  logic [1:0]                iPO_AddressLatchEnable,
    input  logic [1:0]                iPO_CommandLatchEnable,
    output logic [1:0]                oDQSToNAND_P,
    output logic [2*DQWidth-1:0]      oDQToNAND_P,
    output logic                      oDQSOutEnableToPinpad,
    output logic [DQWidth-1:0]        oDQOutEnableToPinpad,
    output logic [NumberOfWays-1:0]   oCEToNAND,
    output logic [1:0]                oWEToNAND_P,
    output logic [1:0]                oREToNAND_P,
    output logic [1:0]                oALEToNAND_P,
    output logic [1:0]                oCLEToNAND_P,
    output logic                      oBusConflict,
    output logic                      oIdle
);

    localparam int unsigned BusWidth = 2 + 2*DQWidth + NumberOfWays + 8;
    localparam logic [BusWidth-1:0] IdleBus = {DQSIdle, {(2*DQWidth){1'b0}}, {NumberOfWays{CEIdle}},
                                               WEIdle, REIdle, ALEIdle, CLEIdle};

    logic [BusWidth-1:0] rPipe [PipelineDepth];
    logic [BusWidth-1:0] wBusIn;
    logic                wDQSTristate, wDQTristate;
    logic                wDQSConflict, wDQConflict;
    logic                wDQSHiZ, wDQHiZ;

    assign wBusIn = {iPO_DQStrobe, iPO_DQ, iPO_ChipEnable, iPO_WriteEnable,
                     iPO_ReadEnable, iPO_AddressLatchEnable, iPO_CommandLatchEnable};

    // Data/strobe pipeline; reset and force-idle load idle levels into every stage
    always_ff @(posedge iSystemClock) begin
        if (iModuleReset || iForceIdle) begin
            for (int unsigned i = 0; i < PipelineDepth; i++) rPipe[i] <= IdleBus;
        end else begin
            rPipe[0] <= wBusIn;
            for (int unsigned i = 1; i < PipelineDepth; i++) rPipe[i] <= rPipe[i-1];
        end
    end

    assign {oDQSToNAND_P, oDQToNAND_P, oCEToNAND, oWEToNAND_P,
            oREToNAND_P, oALEToNAND_P, oCLEToNAND_P} = rPipe[PipelineDepth-1];

    NFC_Tristate_Sequencer #(
        .PipelineDepth    (PipelineDepth),
        .TurnaroundCycles (TurnaroundCycles)
    ) dqsSequencer (
        .iSystemClock (iSystemClock),
        .iModuleReset (iModuleReset),
        .iForceIdle   (iForceIdle),
        .iEnable      (iDQSOutEnable),
        .oTristate    (wDQSTristate),
        .oConflict    (wDQSConflict),
        .oHiZ         (wDQSHiZ)
    );

    NFC_Tristate_Sequencer #(
        .PipelineDepth    (PipelineDepth),
        .TurnaroundCycles (TurnaroundCycles)
    ) dqSequencer (
        .iSystemClock (iSystemClock),
        .iModuleReset (iModuleReset),
        .iForceIdle   (iForceIdle),
        .iEnable      (iDQOutEnable),
        .oTristate    (wDQTristate),
        .oConflict    (wDQConflict),
        .oHiZ         (wDQHiZ)
    );

    assign oDQSOutEnableToPinpad = wDQSTristate;
    assign oDQOutEnableToPinpad  = {DQWidth{wDQTristate}};

    // Registered conflict pulse and bus-released flag
    always_ff @(posedge iSystemClock) begin
        if (iModuleReset || iForceIdle) begin
            oBusConflict <= 1'b0;
            oIdle        <= 1'b1;
        end else begin
            oBusConflict <= wDQSConflict | wDQConflict;
            oIdle        <= wDQSHiZ && wDQHiZ && (&oCEToNAND);
        end
    end

endmodule

// File: tb/tb_nfc_physical_output_gen2.sv
// Directed bench for nfc_physical_output_gen2: default configuration plus a
// 16-bit, single-stage, zero-turnaround instance.
module tb_nfc_physical_output_gen2;

    logic        clk = 1'b0;
    logic        rst;
    logic        force0;
    logic        dqsEn0, dqEn0, dqEn1;
    logic [1:0]  dqs, we, re, ale, cle;
    logic [3:0]  ce;
    logic [15:0] dq0;
    logic [31:0] dq1;

    logic [1:0]  oDqs0, oWe0, oRe0, oAle0, oCle0;
    logic [15:0] oDq0;
    logic        oDqsT0, oConf0, oIdle0;
    logic [7:0]  oDqT0;
    logic [3:0]  oCe0;

    logic [1:0]  oDqs1, oWe1, oRe1, oAle1, oCle1;
    logic [31:0] oDq1;
    logic        oDqsT1, oConf1, oIdle1;
    logic [15:0] oDqT1;
    logic [3:0]  oCe1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    nfc_physical_output_gen2 dut0 (
        .iSystemClock(clk), .iModuleReset(rst), .iDQSOutEnable(dqsEn0), .iDQOutEnable(dqEn0),
        .iForceIdle(force0), .iPO_DQStrobe(dqs), .iPO_DQ(dq0), .iPO_ChipEnable(ce),
        .iPO_ReadEnable(re), .iPO_WriteEnable(we), .iPO_AddressLatchEnable(ale),
        .iPO_CommandLatchEnable(cle), .oDQSToNAND_P(oDqs0), .oDQToNAND_P(oDq0),
        .oDQSOutEnableToPinpad(oDqsT0), .oDQOutEnableToPinpad(oDqT0), .oCEToNAND(oCe0),
        .oWEToNAND_P(oWe0), .oREToNAND_P(oRe0), .oALEToNAND_P(oAle0), .oCLEToNAND_P(oCle0),
        .oBusConflict(oConf0), .oIdle(oIdle0)
    );

    nfc_physical_output_gen2 #(
        .NumberOfWays(4), .DQWidth(16), .PipelineDepth(1), .TurnaroundCycles(0)
    ) dut1 (
        .iSystemClock(clk), .iModuleReset(rst), .iDQSOutEnable(dqsEn0), .iDQOutEnable(dqEn1),
        .iForceIdle(force0), .iPO_DQStrobe(dqs), .iPO_DQ(dq1), .iPO_ChipEnable(ce),
        .iPO_ReadEnable(re), .iPO_WriteEnable(we), .iPO_AddressLatchEnable(ale),
        .iPO_CommandLatchEnable(cle), .oDQSToNAND_P(oDqs1), .oDQToNAND_P(oDq1),
        .oDQSOutEnableToPinpad(oDqsT1), .oDQOutEnableToPinpad(oDqT1), .oCEToNAND(oCe1),
        .oWEToNAND_P(oWe1), .oREToNAND_P(oRe1), .oALEToNAND_P(oAle1), .oCLEToNAND_P(oCle1),
        .oBusConflict(oConf1), .oIdle(oIdle1)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Turnaround/conflict table: request in, then expected T (1 = Hi-Z) and conflict after that edge
    bit tabEn [19] = '{1,1,0,1,0,0,0,0, 1,1,0,1,1,1,1,0,0,0,0};
    bit tabT  [19] = '{1,0,0,1,1,1,1,1, 1,0,0,1,1,1,0,0,1,1,1};
    bit tabC  [19] = '{0,0,0,0,0,1,0,0, 0,0,0,0,0,1,1,0,0,0,0};

    initial begin
        rst = 1'b1; force0 = 1'b0; dqsEn0 = 1'b0; dqEn0 = 1'b0; dqEn1 = 1'b0;
        dqs = 2'b00; we = 2'b11; re = 2'b11; ale = 2'b00; cle = 2'b00; ce = 4'hF;
        dq0 = 16'h0; dq1 = 32'h0;
        repeat (3) tick();

        // Reset state
        checkValue("rst_ce",   32'(oCe0),   32'hF);
        checkValue("rst_we",   32'(oWe0),   32'h3);
        checkValue("rst_re",   32'(oRe0),   32'h3);
        checkValue("rst_ale",  32'(oAle0),  32'h0);
        checkValue("rst_cle",  32'(oCle0),  32'h0);
        checkValue("rst_dqs",  32'(oDqs0),  32'h0);
        checkValue("rst_dq",   32'(oDq0),   32'h0);
        checkValue("rst_dqsT", 32'(oDqsT0), 32'h1);
        checkValue("rst_dqT",  32'(oDqT0),  32'hFF);
        checkValue("rst_conf", 32'(oConf0), 32'h0);
        checkValue("rst_idle", 32'(oIdle0), 32'h1);
        checkValue("rst_dqT1", 32'(oDqT1),  32'hFFFF);

        rst = 1'b0;
        tick();
        checkValue("rel_ce", 32'(oCe0), 32'hF);

        // Two-edge latency of control and strobe lines
        ce = 4'b1110; we = 2'b01; dqs = 2'b10;
        tick();
        checkValue("lat1_ce",  32'(oCe0),  32'hF);
        checkValue("lat1_we",  32'(oWe0),  32'h3);
        checkValue("lat1_dqs", 32'(oDqs0), 32'h0);
        ce = 4'hF; we = 2'b11; dqs = 2'b00;
        tick();
        checkValue("lat2_ce",  32'(oCe0),  32'hE);
        checkValue("lat2_we",  32'(oWe0),  32'h1);
        checkValue("lat2_dqs", 32'(oDqs0), 32'h2);
        tick();
        checkValue("lat3_ce",   32'(oCe0),   32'hF);
        checkValue("lat3_idle", 32'(oIdle0), 32'h0);
        tick();
        checkValue("lat4_idle", 32'(oIdle0), 32'h1);

        // Four-cycle DQ drive aligned with data, then turnaround and idle
        dqEn0 = 1'b1; dq0 = 16'hA55A;
        tick();
        checkValue("drv_T_pre",  32'(oDqT0), 32'hFF);
        checkValue("drv_dq_pre", 32'(oDq0),  32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkValue("drv_T",  32'(oDqT0), 32'h00);
            checkValue("drv_dq", 32'(oDq0),  32'hA55A);
        end
        dqEn0 = 1'b0; dq0 = 16'h0;
        tick();
        checkValue("drv_T_last",  32'(oDqT0), 32'h00);
        checkValue("drv_dq_last", 32'(oDq0),  32'hA55A);
        tick();
        checkValue("rel_T",     32'(oDqT0),  32'hFF);
        checkValue("rel_dq",    32'(oDq0),   32'h0);
        checkValue("rel_idle0", 32'(oIdle0), 32'h0);
        tick();
        checkValue("rel_idle1", 32'(oIdle0), 32'h0);
        tick();
        checkValue("rel_idle2", 32'(oIdle0), 32'h0);
        tick();
        checkValue("rel_idle3", 32'(oIdle0), 32'h1);
        checkValue("rel_dqsT",  32'(oDqsT0), 32'h1);

        // Re-assert during turnaround: one-cycle and persistent requests
        for (int i = 0; i < 19; i++) begin
            dqEn0 = tabEn[i];
            tick();
            checkValue($sformatf("turn_T[%0d]", i),    32'(oDqT0),  tabT[i] ? 32'hFF : 32'h00);
            checkValue($sformatf("turn_conf[%0d]", i), 32'(oConf0), 32'(tabC[i]));
        end

        // Force idle mid-drive flushes data and releases the bus
        dqEn0 = 1'b1; dq0 = 16'hFFFF; ce = 4'b1110;
        tick();
        tick();
        checkValue("fi_pre_T",  32'(oDqT0), 32'h00);
        checkValue("fi_pre_dq", 32'(oDq0),  32'hFFFF);
        checkValue("fi_pre_ce", 32'(oCe0),  32'hE);
        tick();
        force0 = 1'b1;
        tick();
        checkValue("fi_T",    32'(oDqT0),  32'hFF);
        checkValue("fi_ce",   32'(oCe0),   32'hF);
        checkValue("fi_dq",   32'(oDq0),   32'h0);
        checkValue("fi_idle", 32'(oIdle0), 32'h1);
        force0 = 1'b0; dqEn0 = 1'b0; dq0 = 16'h0; ce = 4'hF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkValue("fi_post_dq", 32'(oDq0),  32'h0);
            checkValue("fi_post_T",  32'(oDqT0), 32'hFF);
            checkValue("fi_post_ce", 32'(oCe0),  32'hF);
        end

        // Single-stage, zero-turnaround, 16-bit instance
        dqEn1 = 1'b1; dq1 = 32'h1234_5678;
        tick();
        checkValue("z_T0",  32'(oDqT1),  32'h0000);
        checkValue("z_dq0", oDq1,        32'h1234_5678);
        checkValue("z_c0",  32'(oConf1), 32'h0);
        dqEn1 = 1'b0; dq1 = 32'h0;
        tick();
        checkValue("z_T1",  32'(oDqT1),  32'hFFFF);
        checkValue("z_dq1", oDq1,        32'h0);
        checkValue("z_c1",  32'(oConf1), 32'h0);
        dqEn1 = 1'b1; dq1 = 32'hCAFE_F00D;
        tick();
        checkValue("z_T2",  32'(oDqT1),  32'h0000);
        checkValue("z_dq2", oDq1,        32'hCAFE_F00D);
        checkValue("z_c2",  32'(oConf1), 32'h0);
        dqEn1 = 1'b0; dq1 = 32'h0;
        tick();
        checkValue("z_T3",  32'(oDqT1),  32'hFFFF);
        checkValue("z_c3",  32'(oConf1), 32'h0);
        tick();
        checkValue("z_c4",  32'(oConf1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nfc_physical_output_gen2.md
NFC_PHYSICAL_OUTPUT_GEN2 -- requirements
Module: NFC_Physical_Output_Gen2

Interface
REQ-001 SHALL have parameter NumberOfWays, default 4: number of CE outputs (1..8).
REQ-002 SHALL have parameter DQWidth, default 8: NAND DQ width (8 or 16).
REQ-003 SHALL have parameter PipelineDepth, default 2: input-to-output register stages (1..4).
REQ-004 SHALL have parameter TurnaroundCycles, default 2: forced Hi-Z guard after drive release (0..7).
REQ-005 SHALL have one clock and a synchronous, active-high reset: iSystemClock and iModuleReset.
REQ-006 SHALL have the following ports:
- iSystemClock  in  1  sole clock.
- iModuleReset  in  1  synchronous active-high reset.
- iDQSOutEnable  in  1  request to drive DQS.
- iDQOutEnable  in  1  request to drive DQ.
- iForceIdle  in  1  force bus to idle levels.
- iPO_DQStrobe  in  2  DQS {fall,rise}.
- iPO_DQ  in  2*DQWidth  DQ; [DQWidth-1:0] rise, upper half fall.
- iPO_ChipEnable  in  NumberOfWays  CE, active low.
- iPO_ReadEnable, iPO_WriteEnable, iPO_AddressLatchEnable, iPO_CommandLatchEnable  in  2 each  {fall,rise}.
- oDQSToNAND_P  out  2  DQS phase pair for the DDR output primitive.
- oDQToNAND_P  out  2*DQWidth  DQ phase pairs.
- oDQSOutEnableToPinpad  out  1  DQS tristate; 1 = Hi-Z.
- oDQOutEnableToPinpad  out  DQWidth  DQ tristate per bit; 1 = Hi-Z.
- oCEToNAND  out  NumberOfWays  CE.
- oWEToNAND_P, oREToNAND_P, oALEToNAND_P, oCLEToNAND_P  out  2 each  phase pairs.
- oBusConflict  out  1  one-cycle pulse when a drive request is refused during turnaround.
- oIdle  out  1  bus fully released.

Function
REQ-007 All data and strobe inputs SHALL appear on the matching outputs exactly PipelineDepth edges after being sampled.
REQ-008 Each tristate path (DQS, DQ) SHALL use a three-state FSM: HIZ, DRIVE, TURN.
REQ-009 The FSM SHALL see its enable request delayed by PipelineDepth-1 stages, so T registers align with data.
REQ-010 HIZ->DRIVE SHALL occur on a delayed-enable 1; T goes 0 on that edge.
REQ-011 DRIVE->TURN SHALL occur on a delayed-enable 0; T goes 1 on that edge; the counter loads TurnaroundCycles-1.
REQ-012 TURN SHALL decrement each cycle and go to HIZ when the counter reaches 0; with TurnaroundCycles=0, DRIVE goes directly to HIZ.
REQ-013 A delayed-enable 1 seen while in TURN SHALL be refused, leaving T=1 and the state unchanged, and SHALL pulse oBusConflict for one cycle per refused cycle.
REQ-014 oBusConflict SHALL be the OR of both FSMs' conflict pulses, registered.
REQ-015 All DQWidth bits of oDQOutEnableToPinpad SHALL carry the same T value.
REQ-016 iForceIdle=1 SHALL take effect at the next edge, regardless of PipelineDepth:
- outputs forced to idle levels (REQ-018);
- both FSMs go to HIZ and their counters clear;
- pipeline contents are flushed to idle values.
REQ-017 oIdle SHALL be 1 when both FSMs are in HIZ and all oCEToNAND bits are 1, registered one cycle after that condition.

Reset
REQ-018 On iModuleReset=1, the following SHALL hold at the next edge and until release:
- oCEToNAND all 1; oWEToNAND_P and oREToNAND_P 2'b11;
- oALEToNAND_P and oCLEToNAND_P 2'b00;
- oDQSToNAND_P 0; oDQToNAND_P 0;
- all T outputs 1; oBusConflict 0; oIdle 1;
- FSMs in HIZ; all pipeline stages at these idle values.
REQ-019 Reset asserted mid-DRIVE or mid-TURN SHALL abort the operation, with no conflict pulse.
REQ-020 Reset SHALL take priority over iForceIdle, and iForceIdle over normal operation.

Structure
REQ-021 A shared package NFC_PHY_pkg SHALL hold:
- FSM state encodings (HIZ, DRIVE, TURN);
- idle-level constants for CE, WE, RE, ALE, CLE, DQS;
- parameter range limits.
REQ-022 The FSM SHALL be one sub-module, NFC_Tristate_Sequencer (delay line, FSM, counter, conflict pulse), instantiated twice (DQS, DQ).
REQ-023 Vendor DDR primitives SHALL sit outside this block; all outputs are registered.

Verification
REQ-024 Reset release, then CE=4'b1110 and WE=2'b01 applied, PipelineDepth=2 -> oCEToNAND=4'b1110 and oWEToNAND_P=2'b01 exactly two edges later; prior outputs held at idle values.
REQ-025 iDQOutEnable high for 4 cycles, DQ=16'hA55A -> T=0 for 4 cycles aligned with data, then T=1, then oIdle=1 after 2 turnaround cycles plus 1.
REQ-026 iDQOutEnable re-asserted 1 cycle after release, TurnaroundCycles=2 -> oBusConflict pulses once, T stays 1, DRIVE resumes only if the request persists past TURN.
REQ-027 iForceIdle pulsed mid-DRIVE with DQ=8'hFF in the pipeline -> next edge: T=1, CE=all 1, oDQToNAND_P=0; no stale data emerges afterwards.
REQ-028 TurnaroundCycles=0, PipelineDepth=1, DQWidth=16 -> DRIVE->HIZ in one edge, all 16 T bits equal, and zero conflicts on back-to-back enables separated by one idle cycle.
